// File: rtl/alu_issue_ctrl.sv
// Three-stage issue controller for a 16-bit ALU: IDLE accepts, ISSUE drives the ALU,
// WB writes back and updates the carry/zero flags.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  input  logic [15:0] ra_val,
  input  logic [15:0] rb_val,
  output logic [2:0]  alu_sel,
  output logic [15:0] alu_arg1,
  output logic [15:0] alu_arg2,
  output logic        alu_carry_in,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        flag_c,
  output logic        flag_z,
  output logic        done,
  output logic        skipped,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WB = 2'd2} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;

  state_t      state_q, state_d;
  logic [15:0] instr_q, ra_q, rb_q;
  logic [15:0] res_q;
  logic [2:0]  dst_q;
  logic        exec_q, skip_q, ill_q;
  logic        flag_c_q, flag_z_q;

  logic [3:0]  op;
  logic [1:0]  cz;
  logic        is_add, is_adi, is_nand;
  logic        legal, cond_ok;

  assign op      = instr_q[15:12];
  assign cz      = instr_q[1:0];
  assign is_add  = (op == OP_ADD);
  assign is_adi  = (op == OP_ADI);
  assign is_nand = (op == OP_NAND) && (cz != 2'b11);
  assign legal   = is_add || is_adi || is_nand;

  // Conditional forms look at the flags as they stand during ISSUE.
  always_comb begin
    cond_ok = 1'b1;
    if (is_add || is_nand) begin
      if (cz == 2'b10) cond_ok = flag_c_q;
      else if (cz == 2'b01) cond_ok = flag_z_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ISSUE;
      ISSUE:   state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == IDLE);
    alu_sel      = 3'b000;
    alu_arg1     = 16'h0000;
    alu_arg2     = 16'h0000;
    alu_carry_in = 1'b0;
    if (state_q == ISSUE) begin
      alu_sel  = is_nand ? 3'b001 : 3'b000;
      alu_arg1 = ra_q;
      if (is_adi)
        alu_arg2 = {{10{instr_q[5]}}, instr_q[5:0]};
      else if (is_add && cz == 2'b11)
        alu_arg2 = {rb_q[14:0], 1'b0};
      else
        alu_arg2 = rb_q;
    end
    done    = (state_q == WB);
    wb_en   = done && exec_q;
    skipped = done && skip_q;
    illegal = done && ill_q;
    wb_addr = wb_en ? dst_q : 3'd0;
    wb_data = wb_en ? res_q : 16'h0000;
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= 16'h0000;
      ra_q     <= 16'h0000;
      rb_q     <= 16'h0000;
      res_q    <= 16'h0000;
      dst_q    <= 3'd0;
      exec_q   <= 1'b0;
      skip_q   <= 1'b0;
      ill_q    <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        instr_q <= instr;
        ra_q    <= ra_val;
        rb_q    <= rb_val;
      end
      if (state_q == ISSUE) begin
        res_q  <= alu_result;
        dst_q  <= is_adi ? instr_q[8:6] : instr_q[5:3];
        exec_q <= legal && cond_ok;
        skip_q <= legal && !cond_ok;
        ill_q  <= !legal;
        if (legal && cond_ok) begin
          flag_z_q <= (alu_result == 16'h0000);
          if (!is_nand) flag_c_q <= alu_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural add/nand ALU closing the loop.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr, ra_val, rb_val;
  logic [2:0]  alu_sel;
  logic [15:0] alu_arg1, alu_arg2;
  logic        alu_carry_in;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flag_c, flag_z, done, skipped, illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .ra_val(ra_val), .rb_val(rb_val),
    .alu_sel(alu_sel), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry(alu_carry),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z), .done(done), .skipped(skipped), .illegal(illegal)
  );

  logic [16:0] sum17;
  assign sum17      = {1'b0, alu_arg1} + {1'b0, alu_arg2} + {16'h0000, alu_carry_in};
  assign alu_result = (alu_sel == 3'b001) ? ~(alu_arg1 & alu_arg2) : sum17[15:0];
  assign alu_carry  = (alu_sel == 3'b001) ? 1'b0 : sum17[16];

  function automatic logic [15:0] rtype(input logic [3:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [2:0] rc,
                                        input logic [1:0] cz);
    return {op, ra, rb, rc, 1'b0, cz};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents the instruction, returns #1 into ISSUE.
  task automatic send(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    instr = i; ra_val = a; rb_val = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn instr=%h ra=%h rb=%h", i, a, b);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [2:0] addr,
                        input logic [15:0] data, input logic c, input logic z,
                        input logic sk, input logic il);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_wb_en"}, {31'd0, wb_en}, {31'd0, en});
    if (en) begin
      chk({tag, "_wb_addr"}, {29'd0, wb_addr}, {29'd0, addr});
      chk({tag, "_wb_data"}, {16'd0, wb_data}, {16'd0, data});
    end
    chk({tag, "_flag_c"}, {31'd0, flag_c}, {31'd0, c});
    chk({tag, "_flag_z"}, {31'd0, flag_z}, {31'd0, z});
    chk({tag, "_skipped"}, {31'd0, skipped}, {31'd0, sk});
    chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, il});
  endtask

  initial begin
    in_valid = 1'b0; instr = 16'h0; ra_val = 16'h0; rb_val = 16'h0;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_flags", {30'd0, flag_c, flag_z}, 32'd0);
    chk("rst_done", {29'd0, done, skipped, illegal}, 32'd0);
    chk("rst_wb", {12'd0, wb_en, wb_addr, wb_data}, 32'd0);
    #20 rst_n = 1'b1;
    step();

    // ADD FFFF+0001 -> 0000 carry 1 zero 1
    send(rtype(4'b0000, 3'd1, 3'd2, 3'd3, 2'b00), 16'hFFFF, 16'h0001);
    chk("add_sel", {29'd0, alu_sel}, 32'd0);
    chk("add_args", {alu_arg1, alu_arg2}, 32'hFFFF_0001);
    chk("add_cin", {31'd0, alu_carry_in}, 32'd0);
    chk("add_ready_issue", {31'd0, in_ready}, 32'd0);
    chk("add_done_issue", {31'd0, done}, 32'd0);
    step();
    chk_wb("add", 1'b1, 3'd3, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("add_idle", {30'd0, in_ready, done}, 32'd2);
    chk("add_alu_idle", {alu_arg1, alu_arg2}, 32'd0);

    // ADC executes with C=1, then is skipped with C=0
    send(rtype(4'b0000, 3'd1, 3'd2, 3'd5, 2'b10), 16'h0002, 16'h0003);
    step();
    chk_wb("adc1", 1'b1, 3'd5, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    send(rtype(4'b0000, 3'd1, 3'd2, 3'd5, 2'b10), 16'h0002, 16'h0003);
    step();
    chk_wb("adc2", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Set C=1 again, then NAND keeps C
    send(rtype(4'b0000, 3'd1, 3'd2, 3'd3, 2'b00), 16'hFFFF, 16'h0001);
    step();
    chk_wb("add2", 1'b1, 3'd3, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    send(rtype(4'b0010, 3'd1, 3'd2, 3'd6, 2'b00), 16'hFFFF, 16'hFFFF);
    chk("ndu_sel", {29'd0, alu_sel}, 32'd1);
    step();
    chk_wb("ndu1", 1'b1, 3'd6, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    send(rtype(4'b0010, 3'd1, 3'd2, 3'd7, 2'b00), 16'h0000, 16'h0000);
    step();
    chk_wb("ndu2", 1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // ADL: rb shifted left, bit 15 dropped
    send(rtype(4'b0000, 3'd1, 3'd2, 3'd2, 2'b11), 16'h0001, 16'h8001);
    chk("adl_arg2", {16'd0, alu_arg2}, 32'h0002);
    step();
    chk_wb("adl", 1'b1, 3'd2, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);

    // ADI with imm6=-2 writes rb field
    send({4'b0001, 3'd1, 3'd4, 6'b111110}, 16'h0005, 16'h1234);
    chk("adi_arg2", {16'd0, alu_arg2}, 32'hFFFE);
    step();
    chk_wb("adi", 1'b1, 3'd4, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);

    // NDZ with Z=0 skipped; NAND cz=11 illegal
    send(rtype(4'b0010, 3'd1, 3'd2, 3'd1, 2'b01), 16'h0000, 16'h0000);
    step();
    chk_wb("ndz", 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    send(rtype(4'b0010, 3'd1, 3'd2, 3'd1, 2'b11), 16'h0000, 16'h0000);
    step();
    chk_wb("nand11", 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

    // Opcode 1111 with in_valid held high: next accept only at k+3
    step();
    instr = 16'hF000; ra_val = 16'hFFFF; rb_val = 16'h0001; in_valid = 1'b1;
    step();
    $display("txn instr=%h held valid", instr);
    chk("ill_issue_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("ill_wb_ready", {31'd0, in_ready}, 32'd0);
    chk_wb("ill", 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("ill_k3_ready", {31'd0, in_ready}, 32'd1);
    chk("ill_k3_done", {31'd0, done}, 32'd0);
    step();
    in_valid = 1'b0;
    chk("ill_reaccept", {31'd0, in_ready}, 32'd0);
    step();
    chk_wb("ill2", 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    step();

    // Reset pulsed during ISSUE of an ADD
    send(rtype(4'b0000, 3'd1, 3'd2, 3'd3, 2'b00), 16'hFFFF, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_async_flags", {30'd0, flag_c, flag_z}, 32'd0);
    chk("rst_async_alu", {alu_arg1, alu_arg2}, 32'd0);
    step();
    chk("rst_no_wb", {30'd0, wb_en, done}, 32'd0);
    #2 rst_n = 1'b1;
    send(rtype(4'b0000, 3'd1, 3'd2, 3'd1, 2'b00), 16'h0001, 16'h0001);
    chk("post_rst_accept", {31'd0, in_ready}, 32'd0);
    step();
    chk_wb("post_rst", 1'b1, 3'd1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  instruction and operands present.
REQ-004 in_ready  output  1  block idle and able to accept.
REQ-005 instr  input  16  instruction word: opcode [15:12], ra [11:9], rb [8:6], rc [5:3], cz [1:0], imm6 [5:0].
REQ-006 ra_val, rb_val  input  16 each  register-file operand values, sampled at accept.
REQ-007 alu_sel  output  3  ALU operation: 000 add, 001 nand.
REQ-008 alu_arg1, alu_arg2  output  16 each  ALU operands.
REQ-009 alu_carry_in  output  1  ALU carry input.
REQ-010 alu_result  input  16  ALU result, combinational from ALU drive.
REQ-011 alu_carry  input  1  ALU carry-out.
REQ-012 wb_en  output  1  one-cycle register write strobe.
REQ-013 wb_addr  output  3  destination register.
REQ-014 wb_data  output  16  write-back value.
REQ-015 flag_c, flag_z  output  1 each  architectural carry and zero flags.
REQ-016 done  output  1  one-cycle pulse per accepted instruction (executed, skipped or illegal).
REQ-017 skipped  output  1  qualifies done: condition false, no effect.
REQ-018 illegal  output  1  qualifies done: unsupported opcode, no effect.

Function
REQ-019 States SHALL be IDLE, ISSUE, WB; IDLE->ISSUE on in_valid&&in_ready, ISSUE->WB always, WB->IDLE always.
REQ-020 in_ready SHALL be 1 only in IDLE; instr, ra_val, rb_val SHALL be registered at accept; inputs outside accept ignored.
REQ-021 Supported: opcode 0000 (ADD family), 0010 (NAND family), 0001 (ADI); any other opcode SHALL be illegal.
REQ-022 ADD family cz: 00 ADD, 10 ADC, 01 ADZ, 11 ADL; NAND family cz: 00 NDU, 10 NDC, 01 NDZ, 11 illegal.
REQ-023 In ISSUE: alu_sel=000 for ADD family/ADI, 001 for NAND; alu_arg1=ra_val; alu_arg2=rb_val, except ADL rb_val<<1 (bit 15 dropped) and ADI sign-extended imm6; alu_carry_in=0 always.
REQ-024 Outside ISSUE alu_sel, alu_arg1, alu_arg2, alu_carry_in SHALL be 0.
REQ-025 Condition: ADC/NDC execute only if flag_c=1, ADZ/NDZ only if flag_z=1, evaluated on flag values at ISSUE; others unconditional.
REQ-026 At end of ISSUE, block SHALL register alu_result and alu_carry; Z computed internally as (alu_result==16'h0000), not from any ALU zero output.
REQ-027 In WB for executed instruction: wb_en=1, wb_data=registered result, wb_addr=rc (R-type) or rb (ADI).
REQ-028 Flag update on the WB-entry edge: ADD family and ADI update flag_c and flag_z; NAND family updates flag_z only, flag_c held.
REQ-029 Skipped or illegal instruction: wb_en=0, flags unchanged, done=1 in WB with skipped or illegal=1 respectively.
REQ-030 done SHALL assert only in WB; skipped/illegal SHALL be 0 whenever done=0.
REQ-031 Latency: accept at edge k -> ISSUE cycle k+1 -> WB cycle k+2 -> in_ready=1 cycle k+3; throughput one instruction per 3 cycles.
REQ-032 Arithmetic 16-bit modulo 2^16; carry is bit 16 of the 17-bit sum.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, in_ready=1, wb_en=0, wb_addr=0, wb_data=0, flag_c=0, flag_z=0, done=skipped=illegal=0, ALU drive 0.
REQ-034 Reset during ISSUE or WB SHALL abort the instruction: no write-back, no flag update, no done pulse.
REQ-035 After rst_n deasserts, first accept SHALL be possible on the first rising edge.

Verification
REQ-036 ADD ra_val=16'hFFFF, rb_val=16'h0001, rc=3 -> WB: wb_en=1, wb_addr=3, wb_data=0000, flag_c=1, flag_z=1.
REQ-037 After REQ-036, ADC ra_val=0002, rb_val=0003 -> executes, wb_data=0005, flag_c=0, flag_z=0; repeat ADC -> done=1, skipped=1, wb_en=0, flags unchanged.
REQ-038 NDU ra_val=FFFF, rb_val=FFFF with flag_c=1 -> wb_data=0000, flag_z=1, flag_c stays 1; ADL rb_val=8001, ra_val=0001 -> wb_data=0003, flag_c=0.
REQ-039 ADI ra_val=0005, imm6=6'b111110 (-2), rb=4 -> alu_arg2=FFFE in ISSUE, wb_addr=4, wb_data=0003, flag_c=1.
REQ-040 Opcode 1111 -> done=1, illegal=1, wb_en=0; in_valid held high through WB -> next accept only when in_ready=1 (cycle k+3).
REQ-041 rst_n pulsed low during ISSUE of an ADD -> no wb_en, flags 0, in_ready=1 asynchronously.
